// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID instruction buffer.
// Imported by ifid_buffer and ifid_sat_counter.
package ifid_pkg;

    localparam int IFID_DEPTH_DEFAULT = 2;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/ifid_sat_counter.sv
// 32-bit saturating event counter, asynchronous active-low reset.
// Used by ifid_buffer for its optional performance counters.
module ifid_sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/ifid_buffer.sv
// IF/ID decoupling FIFO of {pc, instr} with flush and NOP fill.
// Define IFID_PERF_CNT_EN to add stall_cnt / flush_cnt outputs.
module ifid_buffer
    import ifid_pkg::*;
#(
    parameter int DEPTH = IFID_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
`ifdef IFID_PERF_CNT_EN
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_pkt_t       mem [DEPTH];
    fetch_pkt_t       head;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    assign head      = mem[rdPtr];
    assign out_pc    = out_valid ? head.pc : 64'd0;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;

    // Storage is not reset; pointers and count gate what is visible.
    always_ff @(posedge clk) begin
        if (reset && push && !flush) begin
            mem[wrPtr] <= '{pc: in_pc, instr: in_instr};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef IFID_PERF_CNT_EN
    ifid_sat_counter uStallCnt (
        .clk   (clk),
        .reset (reset),
        .en    (out_valid && !out_ready),
        .count (stall_cnt)
    );

    ifid_sat_counter uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush),
        .count (flush_cnt)
    );
`endif

endmodule
